microwave_cook_sequencer: RTL and testbench
===========================================

Name: microwave_cook_sequencer

Overview:
- Top-level cooking sequencer for the microwave.
- Takes debounced button pulses and the door switch, and keeps the remaining cook time in seconds.
- Drives the 3-bit mode bus used by the turntable DC-motor PWM controller: RUN spins the motor, all other modes brake it.
- Also drives the buzzer and the cavity lamp, and exports remaining seconds for the FND display.

Parameters:
- CLK_FREQ, 100_000_000: clock cycles per 1 s tick.
- ADD_SEC, 30: seconds added per btn_add pulse.
- MAX_SEC, 999: saturation limit for remain_sec.
- BUZZ_SEC, 3: seconds the buzzer sounds in FINISH.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- btn_start, input, 1: single-cycle pulse, debounced upstream.
- btn_stop, input, 1: single-cycle pulse; pause or cancel.
- btn_add, input, 1: single-cycle pulse; add ADD_SEC seconds.
- door_open, input, 1: level; 1 = door open.
- mode, output, 3: IDLE=000, SET=001, RUN=010, STOP=011, FINISH=100.
- remain_sec, output, 10: remaining cook seconds.
- buzzer, output, 1: 1 = sounding.
- lamp, output, 1: 1 = cavity lamp on.

Behaviour:
- Reset (asynchronous, any state): mode=IDLE, remain_sec=0, prescaler=0, buzz counter=0, buzzer=0, lamp=0.
- All outputs are registered; a transition or decrement is visible on the cycle after its cause.
- Prescaler:
  - Counts 0..CLK_FREQ-1 only in RUN and FINISH.
  - tick = (prescaler==CLK_FREQ-1); the prescaler then wraps to 0.
  - Held (not cleared) in STOP, so a resume continues the partial second.
  - Cleared on every entry to RUN from SET and on every entry to FINISH.
- Add rule: remain_sec <= min(remain_sec+ADD_SEC, MAX_SEC). Compute in 11 bits, then saturate.
- Same-cycle priority, per state: btn_stop > door_open > btn_start > tick > btn_add. A lower-priority event in a cycle where a higher one acts is dropped.
- IDLE:
  - btn_add -> SET, remain_sec=ADD_SEC.
  - btn_start -> ignored (remain_sec is 0).
- SET:
  - btn_add -> add rule.
  - btn_stop -> IDLE, remain_sec=0.
  - btn_start with door closed -> RUN. remain_sec is never 0 in SET.
  - btn_start with door open -> ignored.
- RUN:
  - btn_stop or door_open -> STOP; remain_sec held.
  - tick with remain_sec>1 -> decrement.
  - tick with remain_sec==1 -> remain_sec=0, FINISH.
  - btn_add -> add rule; stays RUN.
- STOP:
  - btn_start with door closed -> RUN.
  - btn_stop -> IDLE, remain_sec=0.
  - btn_add -> add rule.
- FINISH:
  - buzzer=1 while in FINISH.
  - Buzz counter increments on each tick; reaching BUZZ_SEC -> IDLE, buzzer=0.
  - btn_stop or door_open -> IDLE immediately.
  - btn_start and btn_add ignored.
- lamp = door_open OR (mode==RUN), registered.
- No other state-to-state transitions; illegal encodings 101..111 -> IDLE next cycle.

Optional Feature:
- Macro: MWAVE_AUTO_RESUME_EN.
- Defined:
  - A 1-bit flag records that STOP was entered because of door_open.
  - Door closing (door_open 1->0) while in STOP with the flag set -> RUN with no btn_start; flag cleared.
  - STOP entered via btn_stop still requires btn_start to resume.
- Undefined: no flag; STOP always requires btn_start to resume.

Test Plan (CLK_FREQ=10, ADD_SEC=30, MAX_SEC=999, BUZZ_SEC=3):
- Basic cook:
  - Stimulus: reset; btn_add x2; btn_start.
  - Response: remain_sec 30 then 60; mode=RUN.
  - remain_sec decrements every 10 clk; at 0, mode=FINISH, buzzer=1 for 30 clk, then IDLE, buzzer=0.
- Saturation:
  - Stimulus: 34 btn_add pulses.
  - Response: remain_sec=999 (not 1020); mode=SET.
- Door pause/resume:
  - Stimulus: RUN at remain_sec=45, prescaler=4; door_open=1.
  - Response: mode=STOP; remain_sec=45 held; lamp=1; prescaler held at 4.
  - Stimulus: door_open=0, then btn_start.
  - Response: RUN; first decrement 6 clk later.
  - With MWAVE_AUTO_RESUME_EN: RUN on door close with no btn_start.
- Simultaneous events:
  - Stimulus: btn_stop and tick in the same cycle at remain_sec=1.
  - Response: mode=STOP, remain_sec=1, no FINISH.
  - Stimulus: btn_start with door_open=1 in SET.
  - Response: stays SET.
- Cancel and FINISH abort:
  - Stimulus: btn_stop in STOP.
  - Response: IDLE, remain_sec=0.
  - Stimulus: door_open in FINISH.
  - Response: IDLE, buzzer=0 next cycle.
- Reset mid-RUN:
  - Stimulus: assert reset asynchronously, between clock edges.
  - Response: mode=000, remain_sec=0, buzzer=0 without waiting for clk.

Source files
------------

// File: rtl/microwave_cook_sequencer.sv
// Microwave cooking sequencer: button/door handling, 1 s countdown, buzzer, lamp and motor mode.
// Optional MWAVE_AUTO_RESUME_EN: closing the door resumes a cook that the door paused.
module microwave_cook_sequencer #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned ADD_SEC  = 30,
    parameter int unsigned MAX_SEC  = 999,
    parameter int unsigned BUZZ_SEC = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_add,
    input  logic       door_open,
    output logic [2:0] mode,
    output logic [9:0] remain_sec,
    output logic       buzzer,
    output logic       lamp
);

    localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int unsigned BW = (BUZZ_SEC > 1) ? $clog2(BUZZ_SEC + 1) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);
    localparam logic [BW-1:0] BUZZ_LAST  = BW'(BUZZ_SEC - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_SET    = 3'b001,
        ST_RUN    = 3'b010,
        ST_STOP   = 3'b011,
        ST_FINISH = 3'b100
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [BW-1:0] r_buzz;
    logic [9:0]    r_remain;
    logic          r_buzzer;
    logic          r_lamp;

    logic          w_tick;
    logic [10:0]   w_sum;
    logic [9:0]    w_add;
    logic          w_door_close;

    assign w_tick = (r_presc == PRESC_LAST);
    assign w_sum  = 11'(r_remain) + 11'(ADD_SEC);
    assign w_add  = (w_sum > 11'(MAX_SEC)) ? 10'(MAX_SEC) : w_sum[9:0];

`ifdef MWAVE_AUTO_RESUME_EN
    logic r_door_q;
    logic r_door_flag;
    assign w_door_close = r_door_flag & r_door_q & ~door_open;
`else
    assign w_door_close = 1'b0;
`endif

    // Lamp and buzzer default to their "not RUN / not FINISH" values; branches
    // that land in RUN or stay in FINISH override them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_presc  <= '0;
            r_buzz   <= '0;
            r_remain <= '0;
            r_buzzer <= 1'b0;
            r_lamp   <= 1'b0;
`ifdef MWAVE_AUTO_RESUME_EN
            r_door_q    <= 1'b0;
            r_door_flag <= 1'b0;
`endif
        end else begin
            r_lamp   <= door_open;
            r_buzzer <= 1'b0;
`ifdef MWAVE_AUTO_RESUME_EN
            r_door_q <= door_open;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (btn_add) begin
                        r_state  <= ST_SET;
                        r_remain <= w_add;
                    end
                end

                ST_SET: begin
                    if (btn_stop) begin
                        r_state  <= ST_IDLE;
                        r_remain <= '0;
                    end else if (btn_start && !door_open) begin
                        r_state <= ST_RUN;
                        r_presc <= '0;
                        r_lamp  <= 1'b1;
                    end else if (btn_add) begin
                        r_remain <= w_add;
                    end
                end

                ST_RUN: begin
                    if (btn_stop || door_open) begin
                        r_state <= ST_STOP;
`ifdef MWAVE_AUTO_RESUME_EN
                        r_door_flag <= ~btn_stop;
`endif
                    end else if (w_tick && (r_remain <= 10'd1)) begin
                        r_state  <= ST_FINISH;
                        r_remain <= '0;
                        r_presc  <= '0;
                        r_buzz   <= '0;
                        r_buzzer <= 1'b1;
                    end else begin
                        r_lamp <= 1'b1;
                        if (w_tick) begin
                            r_presc  <= '0;
                            r_remain <= r_remain - 10'd1;
                        end else begin
                            r_presc <= r_presc + 1'b1;
                            if (btn_add) begin
                                r_remain <= w_add;
                            end
                        end
                    end
                end

                // Prescaler is left untouched here so a resume finishes the partial second.
                ST_STOP: begin
                    if (btn_stop) begin
                        r_state  <= ST_IDLE;
                        r_remain <= '0;
`ifdef MWAVE_AUTO_RESUME_EN
                        r_door_flag <= 1'b0;
`endif
                    end else if ((btn_start && !door_open) || w_door_close) begin
                        r_state <= ST_RUN;
                        r_lamp  <= 1'b1;
`ifdef MWAVE_AUTO_RESUME_EN
                        r_door_flag <= 1'b0;
`endif
                    end else if (btn_add) begin
                        r_remain <= w_add;
                    end
                end

                ST_FINISH: begin
                    if (btn_stop || door_open || (w_tick && (r_buzz == BUZZ_LAST))) begin
                        r_state <= ST_IDLE;
                        r_presc <= '0;
                        r_buzz  <= '0;
                    end else begin
                        r_buzzer <= 1'b1;
                        if (w_tick) begin
                            r_presc <= '0;
                            r_buzz  <= r_buzz + 1'b1;
                        end else begin
                            r_presc <= r_presc + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_remain <= '0;
                    r_presc  <= '0;
                    r_buzz   <= '0;
                end
            endcase
        end
    end

    assign mode       = r_state;
    assign remain_sec = r_remain;
    assign buzzer     = r_buzzer;
    assign lamp       = r_lamp;

endmodule

// File: tb/tb_microwave_cook_sequencer.sv
// Self-checking bench for microwave_cook_sequencer: directed scenarios plus randomized
// button/door traffic compared every cycle against a behavioural model.
module tb_microwave_cook_sequencer;

    localparam int CF   = 10;
    localparam int ADD  = 30;
    localparam int MAXS = 999;
    localparam int BUZZ = 3;
`ifdef MWAVE_AUTO_RESUME_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_stop = 1'b0;
    logic       btn_add = 1'b0;
    logic       door_open = 1'b0;
    logic [2:0] mode;
    logic [9:0] remain_sec;
    logic       buzzer;
    logic       lamp;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model state: mode number, seconds left, cycles elapsed in the current
    // second, buzzer seconds still owed, and the auto-resume bookkeeping.
    int m_mode, m_rem, m_frac, m_buzz_left;
    bit m_buzzer, m_lamp, m_flag, m_door_q;

    microwave_cook_sequencer #(
        .CLK_FREQ(CF),
        .ADD_SEC (ADD),
        .MAX_SEC (MAXS),
        .BUZZ_SEC(BUZZ)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_stop  (btn_stop),
        .btn_add   (btn_add),
        .door_open (door_open),
        .mode      (mode),
        .remain_sec(remain_sec),
        .buzzer    (buzzer),
        .lamp      (lamp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > MAXS) ? MAXS : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_rem = 0; m_frac = 0; m_buzz_left = 0;
        m_buzzer = 0; m_lamp = 0; m_flag = 0; m_door_q = 0;
    endtask

    // One clock of the cooking rules; highest-priority acting event wins.
    task automatic model_step(input bit st, input bit sp, input bit ad, input bit dr);
        int  nm;
        bit  sec_done;
        nm = m_mode;
        sec_done = (m_frac == CF - 1);
        if (m_mode == 0) begin
            if (ad) begin nm = 1; m_rem = sat(ADD); end
        end else if (m_mode == 1) begin
            if (sp) begin nm = 0; m_rem = 0; end
            else if (st && !dr) begin nm = 2; m_frac = 0; end
            else if (ad) m_rem = sat(m_rem + ADD);
        end else if (m_mode == 2) begin
            if (sp || dr) begin nm = 3; m_flag = !sp; end
            else if (sec_done) begin
                m_frac = 0;
                m_rem = m_rem - 1;
                if (m_rem == 0) begin nm = 4; m_buzz_left = BUZZ; end
            end else begin
                m_frac++;
                if (ad) m_rem = sat(m_rem + ADD);
            end
        end else if (m_mode == 3) begin
            if (sp) begin nm = 0; m_rem = 0; m_flag = 0; end
            else if ((st && !dr) || (AUTO && m_flag && m_door_q && !dr)) begin nm = 2; m_flag = 0; end
            else if (ad) m_rem = sat(m_rem + ADD);
        end else begin
            if (sp || dr) nm = 0;
            else if (sec_done) begin
                m_frac = 0;
                m_buzz_left--;
                if (m_buzz_left == 0) nm = 0;
            end else m_frac++;
        end
        m_mode   = nm;
        m_buzzer = (nm == 4);
        m_lamp   = dr || (nm == 2);
        m_door_q = dr;
    endtask

    task automatic drive(input bit st, input bit sp, input bit ad, input bit dr);
        btn_start = st; btn_stop = sp; btn_add = ad; door_open = dr;
        @(posedge clk);
        model_step(st, sp, ad, dr);
        #1;
        btn_start = 0; btn_stop = 0; btn_add = 0;
    endtask

    task automatic idle(input int n, input bit dr);
        for (int i = 0; i < n; i++) drive(0, 0, 0, dr);
    endtask

    task automatic do_reset();
        chk_en = 0;
        btn_start = 0; btn_stop = 0; btn_add = 0; door_open = 0;
        reset = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        chk("rst_mode", mode, 0);
        chk("rst_remain", remain_sec, 0);
        chk("rst_buzzer", buzzer, 0);
        chk("rst_lamp", lamp, 0);
        chk_en = 1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mode", mode, m_mode);
            chk("remain_sec", remain_sec, m_rem);
            chk("buzzer", buzzer, m_buzzer);
            chk("lamp", lamp, m_lamp);
        end
    end

    initial begin
        int n;
        bit dr;

        // Basic cook
        do_reset();
        drive(0, 0, 1, 0);
        chk("cook_first_add", remain_sec, 30);
        chk("cook_mode_set", mode, 1);
        drive(0, 0, 1, 0);
        chk("cook_second_add", remain_sec, 60);
        drive(1, 0, 0, 0);
        chk("cook_mode_run", mode, 2);
        chk("cook_model_run", m_mode, 2);
        n = 0;
        while (mode != 3'b100 && n < 700) begin
            drive(0, 0, 0, 0);
            n++;
            if (n == 10) chk("cook_first_dec", remain_sec, 59);
        end
        chk("cook_cycles_to_finish", n, 600);
        chk("cook_finish_buzzer", buzzer, 1);
        n = 0;
        while (mode != 3'b000 && n < 100) begin
            drive(0, 0, 0, 0);
            n++;
        end
        chk("cook_buzz_cycles", n, 30);
        chk("cook_end_buzzer", buzzer, 0);

        // Saturation
        do_reset();
        for (int i = 0; i < 34; i++) drive(0, 0, 1, 0);
        chk("sat_remain", remain_sec, 999);
        chk("sat_model", m_rem, 999);
        chk("sat_mode", mode, 1);

        // Door pause / resume at 45 s with 4 cycles into the second
        do_reset();
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        drive(1, 0, 0, 0);
        idle(154, 0);
        chk("door_pre_remain", remain_sec, 45);
        drive(0, 0, 0, 1);
        chk("door_stop_mode", mode, 3);
        chk("door_stop_lamp", lamp, 1);
        idle(3, 1);
        chk("door_held_remain", remain_sec, 45);
        drive(0, 0, 0, 0);
        if (!AUTO) begin
            chk("door_close_stays_stop", mode, 3);
            drive(1, 0, 0, 0);
        end
        chk("door_resume_run", mode, 2);
        n = 0;
        while (remain_sec == 10'd45 && n < 20) begin
            drive(0, 0, 0, 0);
            n++;
        end
        chk("door_resume_cycles", n, 6);
        chk("door_resume_remain", remain_sec, 44);

        // Stop coinciding with the final tick
        do_reset();
        drive(0, 0, 1, 0);
        drive(1, 0, 0, 0);
        idle(299, 0);
        chk("simul_pre_remain", remain_sec, 1);
        drive(0, 1, 0, 0);
        chk("simul_stop_mode", mode, 3);
        chk("simul_stop_remain", remain_sec, 1);
        drive(0, 1, 0, 0);
        chk("cancel_mode", mode, 0);
        chk("cancel_remain", remain_sec, 0);
        drive(0, 0, 1, 0);
        drive(1, 0, 0, 1);
        chk("set_door_start_mode", mode, 1);
        drive(0, 0, 0, 0);

        // FINISH aborted by door
        do_reset();
        drive(0, 0, 1, 0);
        drive(1, 0, 0, 0);
        n = 0;
        while (mode != 3'b100 && n < 400) begin
            drive(0, 0, 0, 0);
            n++;
        end
        chk("abort_reach_finish", n, 300);
        idle(7, 0);
        drive(0, 0, 0, 1);
        chk("abort_mode", mode, 0);
        chk("abort_buzzer", buzzer, 0);
        drive(0, 0, 0, 0);

        // Asynchronous reset in the middle of RUN
        do_reset();
        drive(0, 0, 1, 0);
        drive(1, 0, 0, 0);
        idle(25, 0);
        chk_en = 0;
        #2;
        reset = 1;
        #1;
        chk("async_rst_mode", mode, 0);
        chk("async_rst_remain", remain_sec, 0);
        chk("async_rst_buzzer", buzzer, 0);
        do_reset();

        // Randomized traffic against the model
        dr = 0;
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 1000; i++) begin
                if (dr) dr = ($urandom_range(0, 5) != 0);
                else    dr = ($urandom_range(0, 79) == 0);
                drive($urandom_range(0, 9) == 0,
                      $urandom_range(0, 40 + seg * 60) == 0,
                      $urandom_range(0, 11 + seg * 8) == 0,
                      dr);
            end
        end
        drive(0, 0, 0, 0);
        chk_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
